// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C target: FSM state encoding and field widths.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_BYTE_W = 8;
  localparam int unsigned I2C_CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Multi-flop synchronizer for one bus line with registered-level rise/fall detection.
module i2c_line_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Reset to the idle-high bus level so release after reset creates no false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], line_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/i2c_slave_target.sv
// I2C target answering one 7-bit address; oversampled SCL/SDA, clk >= 8x SCL.
// Optional SCL stretching on read when tx data is not ready: define I2C_CLK_STRETCH_EN.
module i2c_slave_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h55,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic                  scl_oe,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_load,
  output logic                  busy
);

`ifdef I2C_CLK_STRETCH_EN
  localparam bit STRETCH_EN = 1'b1;
`else
  localparam bit STRETCH_EN = 1'b0;
`endif

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst(rst), .line_i(scl_i),
    .level_o(scl_s), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst(rst), .line_i(sda_i),
    .level_o(sda_s), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  // An SDA edge coinciding with an SCL edge is data, not a bus condition.
  logic start_det, stop_det;
  assign start_det = sda_fall & scl_s & ~scl_rise;
  assign stop_det  = sda_rise & scl_s & ~scl_rise;

  i2c_state_e                  state_q, state_d;
  logic [I2C_CNT_W-1:0]        cnt_q, cnt_d;
  logic [I2C_BYTE_W-2:0]       sr_q, sr_d;
  logic [I2C_BYTE_W-1:0]       tx_sr_q, tx_sr_d;
  logic [I2C_BYTE_W-1:0]       rx_data_q, rx_data_d;
  logic                        rw_q, rw_d;
  logic                        sda_oe_q, sda_oe_d;
  logic                        scl_oe_q, scl_oe_d;
  logic                        pend_q, pend_d;
  logic                        rx_valid_q, rx_valid_d;
  logic                        tx_load_q, tx_load_d;
  logic                        busy_q, busy_d;
  logic [I2C_BYTE_W-1:0]       shifted;
  logic                        do_load, load_ok;

  assign shifted = {sr_q, sda_s};
  assign load_ok = tx_valid | ~STRETCH_EN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      tx_sr_q    <= '0;
      rx_data_q  <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      scl_oe_q   <= 1'b0;
      pend_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      tx_sr_q    <= tx_sr_d;
      rx_data_q  <= rx_data_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      scl_oe_q   <= scl_oe_d;
      pend_q     <= pend_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    tx_sr_d    = tx_sr_q;
    rx_data_d  = rx_data_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    scl_oe_d   = scl_oe_q;
    pend_d     = pend_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    busy_d     = busy_q;
    do_load    = 1'b0;

    if (stop_det) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
      pend_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
      pend_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: sda_oe_d = 1'b0;
        ST_ADDR: begin
          if (scl_rise) begin
            sr_d  = shifted[I2C_BYTE_W-2:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (shifted[I2C_BYTE_W-1:1] == SLAVE_ADDR) begin
                state_d = ST_ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = sda_s;
              end else begin
                state_d = ST_WAIT_STOP;
                busy_d  = 1'b0;
              end
            end
          end
        end
        // cnt==8 marks the fall after the 8th bit; the 9th rise wraps it to 0.
        ST_ADDR_ACK, ST_WR_ACK: begin
          if (scl_rise) begin
            cnt_d = '0;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              if (state_q == ST_WR_ACK || !rw_q) state_d = ST_WR_DATA;
              else                               do_load = 1'b1;
            end
          end
        end
        ST_WR_DATA: begin
          if (scl_rise) begin
            sr_d  = shifted[I2C_BYTE_W-2:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              rx_data_d  = shifted;
              rx_valid_d = 1'b1;
              state_d    = ST_WR_ACK;
            end
          end
        end
        ST_RD_DATA: begin
          if (pend_q) begin
            do_load = 1'b1;
          end else if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = ST_RD_ACK;
            end else begin
              tx_sr_d  = tx_sr_q << 1;
              sda_oe_d = ~tx_sr_q[6];
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_d = ST_WAIT_STOP;
            else       cnt_d   = '0;
          end else if (scl_fall && cnt_q == 4'd0) begin
            do_load = 1'b1;
          end
        end
        ST_WAIT_STOP: sda_oe_d = 1'b0;
        default: state_d = ST_IDLE;
      endcase

      if (do_load) begin
        state_d = ST_RD_DATA;
        cnt_d   = '0;
        if (load_ok) begin
          tx_sr_d   = tx_data;
          tx_load_d = 1'b1;
          sda_oe_d  = ~tx_data[7];
          scl_oe_d  = 1'b0;
          pend_d    = 1'b0;
        end else begin
          sda_oe_d = 1'b0;
          scl_oe_d = 1'b1;
          pend_d   = 1'b1;
        end
      end
    end
  end

  assign sda_oe   = sda_oe_q;
  assign scl_oe   = STRETCH_EN ? scl_oe_q : 1'b0;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_load  = tx_load_q;
  assign busy     = busy_q;

endmodule
